ac_ctrl: RTL and testbench
==========================

# ac_ctrl

Command sequencer for the 12-bit accumulator datapath. Accepts one opcode at a time over a valid/ready handshake. Turns it into exclusive one-cycle accumulator strobes (clear, increment, bus write, ALU write-back) plus the memory-read, memory-write and ALU handshakes those strobes depend on. Sits between the instruction decoder and the accumulator/ALU/memory-bus cluster, and is the only driver of the accumulator control pins.

## Interface

Parameters:
- TIMEOUT, 16, max cycles waited for mem_rd_ack / mem_wr_ack / alu_done before aborting (≥1)
- ARG_W, 4, width of the repeat argument for INCN

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- cmd_valid  in  1  command present
- cmd_op  in  3  opcode: 0 NOP, 1 CLR, 2 INC, 3 LOAD, 4 STORE, 5 ALU, 6 INCN, 7 illegal
- cmd_arg  in  ARG_W  repeat count for INCN, ignored otherwise
- cmd_ready  out  1  block idle, command accepted when cmd_valid & cmd_ready at a rising edge
- done  out  1  one-cycle completion pulse
- err  out  1  valid only with done: illegal opcode or timeout
- ac_clr_en, ac_inc_en, ac_write_en, ac_alu_to_ac  out  1 each  accumulator strobes
- bus_sel_mem  out  1  memory drives bus (LOAD write cycle)
- bus_sel_ac  out  1  accumulator drives bus (STORE)
- mem_rd_req / mem_rd_ack  out / in  1  memory read handshake
- mem_wr_req / mem_wr_ack  out / in  1  memory write handshake
- alu_start  out  1  one-cycle ALU launch pulse
- alu_done  in  1  ALU result valid on alu_out

## Operation

- States: IDLE, EXEC, INC_LOOP, RD_WAIT, LOAD_WR, WR_WAIT, ALU_START, ALU_WAIT, ALU_WB, DONE.
- All outputs are registered, Moore-decoded from state.
- At most one of the four ac_* strobes is high in any cycle. bus_sel_mem and bus_sel_ac are never high together.
- Reset, asynchronous, any state: state goes to IDLE, counters clear, every output 0 including cmd_ready. cmd_ready rises at the first rising edge after rst_n deasserts.
- Reset mid-operation abandons the command. No done is produced, and no strobe is issued after reset.
- IDLE: cmd_ready=1. On accept, opcode and argument are latched, and cmd_ready=0 until the cycle after done.
- NOP or illegal opcode: go directly to DONE. err=1 for illegal.
- CLR / INC: EXEC asserts ac_clr_en / ac_inc_en for one cycle, then DONE.
- INCN, arg=k: INC_LOOP asserts ac_inc_en for k consecutive cycles (down-counter), then DONE. k=0 behaves as NOP.
- LOAD:
  - RD_WAIT holds mem_rd_req=1 until mem_rd_ack is sampled high.
  - LOAD_WR then asserts ac_write_en=1 and bus_sel_mem=1 for one cycle, then DONE.
- STORE: WR_WAIT holds bus_sel_ac=1 and mem_wr_req=1 until mem_wr_ack is sampled high, then DONE.
- ALU:
  - ALU_START pulses alu_start.
  - ALU_WAIT waits for alu_done. alu_done is sampled only in ALU_WAIT.
  - ALU_WB asserts ac_alu_to_ac for one cycle, then DONE.
- Watchdog in RD_WAIT, WR_WAIT and ALU_WAIT:
  - A counter clears on state entry and increments each waiting cycle.
  - After TIMEOUT cycles without the response, go to DONE with err=1. Request lines drop and no ac_* strobe is issued.
  - A response sampled on the same edge as expiry wins, and the normal path is taken.
- DONE: done=1 for one cycle, err as set. Then IDLE.
- cmd_valid is ignored while cmd_ready=0.

## Timing

Accept edge = E0; cycle n = the cycle after edge En−1.
- NOP: done in cycle 1, cmd_ready in cycle 2.
- CLR / INC: strobe in cycle 1, done in cycle 2, cmd_ready in cycle 3.
- INCN k≥1: ac_inc_en in cycles 1..k, done in cycle k+1.
- LOAD:
  - mem_rd_req from cycle 1.
  - If ack is sampled at the end of cycle j: ac_write_en in cycle j+1, done in cycle j+2.
  - Minimum 3 cycles to done.
- STORE: mem_wr_req from cycle 1. Ack at the end of cycle j gives done in cycle j+1.
- ALU: alu_start in cycle 1, ALU_WAIT from cycle 2.
  - If alu_done is sampled at the end of cycle j (j≥2): ac_alu_to_ac in cycle j+1, done in cycle j+2.
- Timeout: a wait state entered in cycle s with no response ends with done=1 and err=1 in cycle s+TIMEOUT.
- Back-to-back commands: next accept no earlier than the cycle after done.

## Test plan

- Reset behaviour: assert rst_n=0 mid-LOAD with mem_rd_req high → all outputs 0 immediately, no done. After release, cmd_ready=1 one edge later.
- CLR, then INCN arg=5 → ac_clr_en in cycle 1, done in cycle 2. INCN gives ac_inc_en exactly 5 consecutive cycles, then done with err=0. Repeat with arg=0 → done in cycle 1, no strobe.
- LOAD with ack delayed 3 cycles → mem_rd_req high cycles 1–4, ac_write_en and bus_sel_mem in cycle 5, done in cycle 6. Check strobe exclusivity every cycle.
- ALU with alu_done held high from cycle 1 → alu_done is not used in cycle 1. Sampled at end of cycle 2, ac_alu_to_ac in cycle 3, done in cycle 4.
- STORE with no ack, TIMEOUT=16 → mem_wr_req and bus_sel_ac high cycles 1–16, done=1 and err=1 in cycle 17, no ac_* strobe. Repeat with ack on the expiry edge → done with err=0.
- Opcode 7 → done=1 and err=1 in cycle 1, no strobes. Toggle cmd_valid while busy → no second accept.

Source files
------------

// File: rtl/ac_ctrl.sv
// ac_ctrl: command sequencer for the 12-bit accumulator datapath.
// Rev 1.0 - registered Moore outputs, watchdog on every external wait.
`default_nettype none

module ac_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int ARG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [ARG_W-1:0] cmd_arg,
  output logic             cmd_ready,
  output logic             done,
  output logic             err,
  output logic             ac_clr_en,
  output logic             ac_inc_en,
  output logic             ac_write_en,
  output logic             ac_alu_to_ac,
  output logic             bus_sel_mem,
  output logic             bus_sel_ac,
  output logic             mem_rd_req,
  input  logic             mem_rd_ack,
  output logic             mem_wr_req,
  input  logic             mem_wr_ack,
  output logic             alu_start,
  input  logic             alu_done
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_CLR   = 3'd1;
  localparam logic [2:0] OP_INC   = 3'd2;
  localparam logic [2:0] OP_LOAD  = 3'd3;
  localparam logic [2:0] OP_STORE = 3'd4;
  localparam logic [2:0] OP_ALU   = 3'd5;
  localparam logic [2:0] OP_INCN  = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_EXEC, S_INC_LOOP, S_RD_WAIT, S_LOAD_WR,
    S_WR_WAIT, S_ALU_START, S_ALU_WAIT, S_ALU_WB, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [ARG_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic cmd_ready_q, cmd_ready_d, done_q, done_d, err_q, err_d;
  logic ac_clr_en_q, ac_clr_en_d, ac_inc_en_q, ac_inc_en_d;
  logic ac_write_en_q, ac_write_en_d, ac_alu_to_ac_q, ac_alu_to_ac_d;
  logic bus_sel_mem_q, bus_sel_mem_d, bus_sel_ac_q, bus_sel_ac_d;
  logic mem_rd_req_q, mem_rd_req_d, mem_wr_req_q, mem_wr_req_d;
  logic alu_start_q, alu_start_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // cmd_ready_q gates acceptance so nothing is taken on the first edge after reset
        if (cmd_valid && cmd_ready_q) begin
          op_d  = cmd_op;
          cnt_d = cmd_arg;
          wd_d  = '0;
          case (cmd_op)
            OP_NOP:         state_d = S_DONE;
            OP_CLR, OP_INC: state_d = S_EXEC;
            OP_LOAD:        state_d = S_RD_WAIT;
            OP_STORE:       state_d = S_WR_WAIT;
            OP_ALU:         state_d = S_ALU_START;
            OP_INCN:        state_d = (cmd_arg == '0) ? S_DONE : S_INC_LOOP;
            default: begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_EXEC: state_d = S_DONE;
      S_INC_LOOP: begin
        if (cnt_q <= ARG_W'(1)) state_d = S_DONE;
        else                    cnt_d   = cnt_q - ARG_W'(1);
      end
      // In each wait state a response on the expiry edge takes priority over the timeout
      S_RD_WAIT: begin
        if (mem_rd_ack)            state_d = S_LOAD_WR;
        else if (wd_q == WD_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else                   wd_d = wd_q + WD_W'(1);
      end
      S_LOAD_WR: state_d = S_DONE;
      S_WR_WAIT: begin
        if (mem_wr_ack)            state_d = S_DONE;
        else if (wd_q == WD_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else                   wd_d = wd_q + WD_W'(1);
      end
      S_ALU_START: begin
        state_d = S_ALU_WAIT;
        wd_d    = '0;
      end
      S_ALU_WAIT: begin
        if (alu_done)              state_d = S_ALU_WB;
        else if (wd_q == WD_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else                   wd_d = wd_q + WD_W'(1);
      end
      S_ALU_WB: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the flops line up with the state they describe
    cmd_ready_d    = (state_d == S_IDLE);
    done_d         = (state_d == S_DONE);
    ac_clr_en_d    = (state_d == S_EXEC) && (op_d == OP_CLR);
    ac_inc_en_d    = ((state_d == S_EXEC) && (op_d == OP_INC)) || (state_d == S_INC_LOOP);
    ac_write_en_d  = (state_d == S_LOAD_WR);
    bus_sel_mem_d  = (state_d == S_LOAD_WR);
    ac_alu_to_ac_d = (state_d == S_ALU_WB);
    bus_sel_ac_d   = (state_d == S_WR_WAIT);
    mem_wr_req_d   = (state_d == S_WR_WAIT);
    mem_rd_req_d   = (state_d == S_RD_WAIT);
    alu_start_d    = (state_d == S_ALU_START);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      cnt_q          <= '0;
      wd_q           <= '0;
      cmd_ready_q    <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      ac_clr_en_q    <= 1'b0;
      ac_inc_en_q    <= 1'b0;
      ac_write_en_q  <= 1'b0;
      ac_alu_to_ac_q <= 1'b0;
      bus_sel_mem_q  <= 1'b0;
      bus_sel_ac_q   <= 1'b0;
      mem_rd_req_q   <= 1'b0;
      mem_wr_req_q   <= 1'b0;
      alu_start_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      cnt_q          <= cnt_d;
      wd_q           <= wd_d;
      cmd_ready_q    <= cmd_ready_d;
      done_q         <= done_d;
      err_q          <= err_d;
      ac_clr_en_q    <= ac_clr_en_d;
      ac_inc_en_q    <= ac_inc_en_d;
      ac_write_en_q  <= ac_write_en_d;
      ac_alu_to_ac_q <= ac_alu_to_ac_d;
      bus_sel_mem_q  <= bus_sel_mem_d;
      bus_sel_ac_q   <= bus_sel_ac_d;
      mem_rd_req_q   <= mem_rd_req_d;
      mem_wr_req_q   <= mem_wr_req_d;
      alu_start_q    <= alu_start_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign done         = done_q;
  assign err          = err_q;
  assign ac_clr_en    = ac_clr_en_q;
  assign ac_inc_en    = ac_inc_en_q;
  assign ac_write_en  = ac_write_en_q;
  assign ac_alu_to_ac = ac_alu_to_ac_q;
  assign bus_sel_mem  = bus_sel_mem_q;
  assign bus_sel_ac   = bus_sel_ac_q;
  assign mem_rd_req   = mem_rd_req_q;
  assign mem_wr_req   = mem_wr_req_q;
  assign alu_start    = alu_start_q;

endmodule

`default_nettype wire

// File: tb/tb_ac_ctrl.sv
// tb_ac_ctrl: directed bench for ac_ctrl against a cycle-indexed timing model.
`default_nettype none

module tb_ac_ctrl;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_arg = 4'd0;
  logic       mem_rd_ack = 1'b0, mem_wr_ack = 1'b0, alu_done = 1'b0;
  logic cmd_ready, done, err, ac_clr_en, ac_inc_en, ac_write_en, ac_alu_to_ac;
  logic bus_sel_mem, bus_sel_ac, mem_rd_req, mem_wr_req, alu_start;

  int errors = 0;
  int checks = 0;
  logic        chk_en = 1'b0;
  logic [11:0] exp_vec = '0;

  ac_ctrl #(.TIMEOUT(T), .ARG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_ready(cmd_ready), .done(done), .err(err), .ac_clr_en(ac_clr_en),
    .ac_inc_en(ac_inc_en), .ac_write_en(ac_write_en), .ac_alu_to_ac(ac_alu_to_ac),
    .bus_sel_mem(bus_sel_mem), .bus_sel_ac(bus_sel_ac), .mem_rd_req(mem_rd_req),
    .mem_rd_ack(mem_rd_ack), .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack),
    .alu_start(alu_start), .alu_done(alu_done)
  );

  always #5 clk = ~clk;

  // {cmd_ready, done, err, clr, inc, wr, alu2ac, bus_mem, bus_ac, rd_req, wr_req, alu_start}
  wire [11:0] dut_vec = {cmd_ready, done, err, ac_clr_en, ac_inc_en, ac_write_en,
                         ac_alu_to_ac, bus_sel_mem, bus_sel_ac, mem_rd_req, mem_wr_req, alu_start};

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected outputs in cycle n after accept (n=0 is the accept cycle); d returns the done cycle.
  // rs is the first cycle the response input is held high (0 = never).
  function automatic logic [11:0] model(input logic [2:0] op, input int arg, input int rs,
                                        input int n, output int d);
    logic rdy, dn, er, clr, inc, wr, a2a, bm, ba, rr, wq, as_;
    int j;
    {rdy, dn, er, clr, inc, wr, a2a, bm, ba, rr, wq, as_} = '0;
    if (rs == 0)       j = 1000;
    else if (op == 3'd5) j = (rs < 2) ? 2 : rs;
    else               j = (rs < 1) ? 1 : rs;
    d = 1;
    case (op)
      3'd1: begin d = 2; clr = (n == 1); end
      3'd2: begin d = 2; inc = (n == 1); end
      3'd3: if (j <= T) begin
              rr = (n >= 1 && n <= j); wr = (n == j + 1); bm = wr; d = j + 2;
            end else begin
              rr = (n >= 1 && n <= T); d = T + 1; er = 1'b1;
            end
      3'd4: if (j <= T) begin
              ba = (n >= 1 && n <= j); d = j + 1;
            end else begin
              ba = (n >= 1 && n <= T); d = T + 1; er = 1'b1;
            end
      3'd5: begin
              as_ = (n == 1);
              if (j <= T + 1) begin a2a = (n == j + 1); d = j + 2; end
              else begin d = T + 2; er = 1'b1; end
            end
      3'd6: begin d = (arg == 0) ? 1 : arg + 1; inc = (n >= 1 && n <= arg); end
      3'd7: er = 1'b1;
      default: d = 1;
    endcase
    wq  = ba;
    dn  = (n == d);
    er  = er && dn;
    rdy = (n == 0) || (n == d + 1);
    return {rdy, dn, er, clr, inc, wr, a2a, bm, ba, rr, wq, as_};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cycle_outputs", dut_vec, exp_vec);
      checks++;
      if (($countones({ac_clr_en, ac_inc_en, ac_write_en, ac_alu_to_ac}) > 1) ||
          (bus_sel_mem && bus_sel_ac)) begin
        errors++;
        $display("FAIL exclusivity: got %h expected at most one strobe/bus select", dut_vec);
      end
    end
  end

  task automatic run(input logic [2:0] op, input int arg, input int rs, input bit noise,
                     input int lit_done, input bit lit_err);
    int d, seen, seen_err;
    logic [11:0] e;
    seen = -1;
    seen_err = 0;
    e = model(op, arg, rs, 0, d);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = 4'(arg);
    exp_vec = e; chk_en = 1'b1;
    for (int n = 1; n <= d + 1; n++) begin
      @(posedge clk); #1;
      cmd_valid = noise && (n <= d) ? n[0] : 1'b0;
      cmd_op = 3'd1; cmd_arg = 4'd3;
      mem_rd_ack = (op == 3'd3) && rs != 0 && n >= rs && n <= d;
      mem_wr_ack = (op == 3'd4) && rs != 0 && n >= rs && n <= d;
      alu_done   = (op == 3'd5) && rs != 0 && n >= rs && n <= d;
      exp_vec = model(op, arg, rs, n, d);
      @(negedge clk);
      if (done && seen < 0) begin seen = n; seen_err = int'(err); end
    end
    chk_en = 1'b0;
    chk("done_cycle", 12'(seen), 12'(lit_done));
    chk("done_err", 12'(seen_err), 12'(lit_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int dd;
    #12;
    chk("reset_outputs", dut_vec, 12'h000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("pre_first_edge", dut_vec, 12'h000);
    @(posedge clk); #1;
    chk("ready_after_reset", dut_vec, 12'h800);

    run(3'd1, 0, 0, 1'b0, 2, 1'b0);   // CLR
    run(3'd6, 5, 0, 1'b1, 6, 1'b0);   // INCN 5, cmd_valid toggling while busy
    run(3'd6, 0, 0, 1'b0, 1, 1'b0);   // INCN 0
    run(3'd2, 0, 0, 1'b0, 2, 1'b0);   // INC
    run(3'd0, 0, 0, 1'b0, 1, 1'b0);   // NOP
    run(3'd3, 0, 4, 1'b0, 6, 1'b0);   // LOAD, ack sampled end of cycle 4
    run(3'd3, 0, 1, 1'b0, 3, 1'b0);   // LOAD, fastest ack
    run(3'd5, 0, 1, 1'b0, 4, 1'b0);   // ALU, alu_done high from cycle 1
    run(3'd5, 0, 5, 1'b0, 7, 1'b0);
    run(3'd4, 0, 0, 1'b0, 17, 1'b1);  // STORE timeout
    run(3'd4, 0, 16, 1'b0, 17, 1'b0); // STORE ack on expiry edge
    run(3'd4, 0, 1, 1'b0, 2, 1'b0);
    run(3'd3, 0, 0, 1'b0, 17, 1'b1);  // LOAD timeout
    run(3'd5, 0, 0, 1'b0, 18, 1'b1);  // ALU timeout
    run(3'd5, 0, 17, 1'b0, 19, 1'b0); // ALU done on expiry edge
    run(3'd7, 0, 0, 1'b1, 1, 1'b1);   // illegal opcode

    // Reset mid-LOAD while mem_rd_req is high
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_arg = 4'd0;
    exp_vec = model(3'd3, 0, 0, 0, dd); chk_en = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      exp_vec = model(3'd3, 0, 0, n, dd);
      @(negedge clk);
    end
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset", dut_vec, 12'h000);
    @(posedge clk); @(posedge clk); #1;
    chk("held_in_reset", dut_vec, 12'h000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_no_ready", dut_vec, 12'h000);
    @(posedge clk); #1;
    chk("release_ready", dut_vec, 12'h800);
    @(posedge clk); #1;
    chk("idle_no_done", dut_vec, 12'h800);

    run(3'd1, 0, 0, 1'b0, 2, 1'b0);   // still functional after reset

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
